// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - time-setting control: button edits of a shadow time with commit/timeout
// Optional hold-to-repeat stepping is built when TIME_SET_AUTOREPEAT_EN is defined.
module time_set_ctrl #(
  parameter int                            NUM_FIELDS   = 3,
  parameter int                            FIELD_W      = 6,
  parameter logic [NUM_FIELDS*FIELD_W-1:0] FIELD_MAX    = {6'd23, 6'd59, 6'd59},
  parameter int unsigned                   REPEAT_DELAY = 50_000_000,
  parameter int unsigned                   REPEAT_RATE  = 10_000_000,
  parameter int unsigned                   TIMEOUT      = 1_000_000_000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_btn_l,
  input  logic                          i_btn_r,
  input  logic                          i_btn_u,
  input  logic                          i_btn_d,
  input  logic [NUM_FIELDS*FIELD_W-1:0] i_cur_time,
  output logic [NUM_FIELDS*FIELD_W-1:0] o_edit_time,
  output logic [1:0]                    o_field_sel,
  output logic                          o_set_active,
  output logic                          o_commit,
  output logic                          o_timeout
);

  localparam int TW = NUM_FIELDS * FIELD_W;
  localparam logic [1:0] TOP_SEL = 2'(NUM_FIELDS - 1);
  localparam logic [FIELD_W-1:0] ONE = FIELD_W'(1);

  typedef enum logic {S_IDLE, S_EDIT} state_t;

  state_t              state_q, state_d;
  logic [3:0]          btn_q;
  logic [TW-1:0]       shadow_q, shadow_d;
  logic [1:0]          sel_q, sel_d;
  logic                commit_q, commit_d;
  logic                timeout_q, timeout_d;
  logic [31:0]         to_cnt_q, to_cnt_d;

  logic                l_edge, r_edge, u_edge, d_edge;
  logic                up_lvl, dn_lvl, nav_l, nav_r;
  logic                step_up, step_dn, rep_fire, activity;
  logic [FIELD_W-1:0]  cur_val, cur_max, stepped;

  assign l_edge = i_btn_l & ~btn_q[0];
  assign r_edge = i_btn_r & ~btn_q[1];
  assign u_edge = i_btn_u & ~btn_q[2];
  assign d_edge = i_btn_d & ~btn_q[3];

  // Up and down held together cancel each other out entirely.
  assign up_lvl = i_btn_u & ~i_btn_d;
  assign dn_lvl = i_btn_d & ~i_btn_u;
  assign nav_l  = l_edge & ~r_edge;
  assign nav_r  = r_edge & ~l_edge;

  assign step_up  = up_lvl & (u_edge | rep_fire);
  assign step_dn  = dn_lvl & (d_edge | rep_fire);
  assign activity = l_edge | r_edge | u_edge | d_edge | rep_fire;

`ifdef TIME_SET_AUTOREPEAT_EN
  // rep_cnt counts cycles since the last step; 0 means no repeat is armed.
  logic [31:0] rep_cnt_q, rep_cnt_d;
  logic        rep_first_q, rep_first_d;

  assign rep_fire = (up_lvl | dn_lvl) && (rep_cnt_q != 32'd0) &&
                    (rep_cnt_q == (rep_first_q ? REPEAT_DELAY : REPEAT_RATE));

  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_first_d = rep_first_q;
    if (state_q != S_EDIT || !(up_lvl | dn_lvl)) begin
      rep_cnt_d   = 32'd0;
      rep_first_d = 1'b1;
    end else if ((u_edge & up_lvl) | (d_edge & dn_lvl)) begin
      rep_cnt_d   = 32'd1;
      rep_first_d = 1'b1;
    end else if (rep_fire) begin
      rep_cnt_d   = 32'd1;
      rep_first_d = 1'b0;
    end else if (rep_cnt_q != 32'd0) begin
      rep_cnt_d   = rep_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt_q   <= 32'd0;
      rep_first_q <= 1'b1;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_comb begin
    cur_val = '0;
    cur_max = '0;
    for (int f = 0; f < NUM_FIELDS; f++) begin
      if (f == int'(sel_q)) begin
        cur_val = shadow_q[f*FIELD_W +: FIELD_W];
        cur_max = FIELD_MAX[f*FIELD_W +: FIELD_W];
      end
    end

    // Out-of-range values snap to a legal value on either step direction.
    if (step_up) begin
      stepped = (cur_val >= cur_max) ? '0 : cur_val + ONE;
    end else begin
      stepped = (cur_val == '0 || cur_val > cur_max) ? cur_max : cur_val - ONE;
    end

    state_d   = state_q;
    shadow_d  = shadow_q;
    sel_d     = sel_q;
    commit_d  = 1'b0;
    timeout_d = 1'b0;
    to_cnt_d  = to_cnt_q;

    case (state_q)
      S_IDLE: begin
        to_cnt_d = 32'd0;
        if (nav_l | nav_r) begin
          state_d  = S_EDIT;
          shadow_d = i_cur_time;
          sel_d    = TOP_SEL;
        end
      end
      S_EDIT: begin
        if (nav_r) begin
          if (sel_q == 2'd0) begin
            state_d  = S_IDLE;
            commit_d = 1'b1;
          end else begin
            sel_d = sel_q - 2'd1;
          end
        end else if (nav_l) begin
          if (sel_q == TOP_SEL) state_d = S_IDLE;
          else                  sel_d   = sel_q + 2'd1;
        end else if (step_up | step_dn) begin
          for (int f = 0; f < NUM_FIELDS; f++) begin
            if (f == int'(sel_q)) shadow_d[f*FIELD_W +: FIELD_W] = stepped;
          end
        end

        if (activity) begin
          to_cnt_d = 32'd0;
        end else if (TIMEOUT != 0) begin
          if (to_cnt_q + 32'd1 == TIMEOUT) begin
            state_d   = S_IDLE;
            timeout_d = 1'b1;
            to_cnt_d  = 32'd0;
          end else begin
            to_cnt_d = to_cnt_q + 32'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      btn_q     <= 4'd0;
      shadow_q  <= '0;
      sel_q     <= 2'd0;
      commit_q  <= 1'b0;
      timeout_q <= 1'b0;
      to_cnt_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      btn_q     <= {i_btn_d, i_btn_u, i_btn_r, i_btn_l};
      shadow_q  <= shadow_d;
      sel_q     <= sel_d;
      commit_q  <= commit_d;
      timeout_q <= timeout_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  assign o_edit_time  = shadow_q;
  assign o_field_sel  = sel_q;
  assign o_set_active = (state_q == S_EDIT);
  assign o_commit     = commit_q;
  assign o_timeout    = timeout_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb/tb_time_set_ctrl.sv - directed and randomized checks of time_set_ctrl against a behavioural model
`timescale 1ns/1ps
module tb_time_set_ctrl;

  localparam int NF = 3;
  localparam int FW = 6;
  localparam int RD = 10;
  localparam int RR = 4;
  localparam int TO = 20;
  localparam int MAXV [3] = '{59, 59, 23};

  logic              clk = 1'b0;
  logic              rst;
  logic              bl, br, bu, bd;
  logic [NF*FW-1:0]  cur_time;
  logic [NF*FW-1:0]  edit_time;
  logic [1:0]        field_sel;
  logic              set_active, commit, timeout;

  int   errors, checks, k, n;
  int   m_f [3];
  int   m_sel, m_idle, hold_n;
  bit   m_active, m_commit, m_timeout, hold_ok;
  logic [3:0] m_prev;

  time_set_ctrl #(
    .NUM_FIELDS(NF), .FIELD_W(FW), .FIELD_MAX({6'd23, 6'd59, 6'd59}),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .i_btn_l(bl), .i_btn_r(br), .i_btn_u(bu), .i_btn_d(bd),
    .i_cur_time(cur_time), .o_edit_time(edit_time), .o_field_sel(field_sel),
    .o_set_active(set_active), .o_commit(commit), .o_timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [NF*FW-1:0] m_pack();
    logic [NF*FW-1:0] p;
    for (int f = 0; f < NF; f++) p[f*FW +: FW] = FW'(m_f[f]);
    return p;
  endfunction

  task automatic model_reset();
    for (int f = 0; f < NF; f++) m_f[f] = 0;
    m_sel = 0; m_idle = 0; hold_n = 0;
    m_active = 0; m_commit = 0; m_timeout = 0; hold_ok = 0;
    m_prev = 4'd0;
  endtask

  // One clock of the watch-setting rules, written from the user's point of view.
  task automatic model_update();
    bit le, re, ue, de, eu, ed, nl, nr, rep, act;
    int mx;
    if (rst) begin
      model_reset();
      return;
    end
    le = bl && !m_prev[0]; re = br && !m_prev[1];
    ue = bu && !m_prev[2]; de = bd && !m_prev[3];
    eu = bu && !bd;        ed = bd && !bu;
    nl = le && !re;        nr = re && !le;
    rep = 0; m_commit = 0; m_timeout = 0;
`ifdef TIME_SET_AUTOREPEAT_EN
    if (m_active && ((eu && ue) || (ed && de))) begin
      hold_ok = 1; hold_n = 0;
    end else if (m_active && hold_ok && (eu || ed)) begin
      hold_n++;
      rep = (hold_n >= RD) && ((hold_n - RD) % RR == 0);
    end else begin
      hold_ok = 0; hold_n = 0;
    end
`endif
    act = le || re || ue || de || rep;
    if (!m_active) begin
      if (nl || nr) begin
        m_active = 1;
        for (int f = 0; f < NF; f++) m_f[f] = int'(cur_time[f*FW +: FW]);
        m_sel = NF - 1; m_idle = 0;
      end
    end else begin
      mx = MAXV[m_sel];
      if (nr) begin
        if (m_sel == 0) begin m_active = 0; m_commit = 1; end
        else m_sel--;
      end else if (nl) begin
        if (m_sel == NF - 1) m_active = 0;
        else m_sel++;
      end else if (eu && (ue || rep)) begin
        m_f[m_sel] = (m_f[m_sel] >= mx) ? 0 : m_f[m_sel] + 1;
      end else if (ed && (de || rep)) begin
        m_f[m_sel] = (m_f[m_sel] == 0 || m_f[m_sel] > mx) ? mx : m_f[m_sel] - 1;
      end
      if (act) m_idle = 0;
      else begin
        m_idle++;
        if (m_idle == TO) begin m_active = 0; m_timeout = 1; m_idle = 0; end
      end
    end
    m_prev = {bd, bu, br, bl};
  endtask

  task automatic compare_all();
    chk("edit_time", edit_time, m_pack());
    chk("field_sel", field_sel, m_sel);
    chk("set_active", set_active, m_active);
    chk("commit", commit, m_commit);
    chk("timeout", timeout, m_timeout);
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic step(input logic l, input logic r, input logic u, input logic d);
    bl = l; br = r; bu = u; bd = d;
    tick();
  endtask

  initial begin
    errors = 0; checks = 0;
    rst = 1'b1; bl = 0; br = 0; bu = 0; bd = 0;
    cur_time = {6'd12, 6'd34, 6'd56};
    model_reset();
    tick(); tick();
    chk("rst_edit_time", edit_time, 0);
    chk("rst_field_sel", field_sel, 0);
    chk("rst_active", set_active, 0);
    rst = 1'b0;
    tick();

    step(0, 1, 0, 0);
    chk("enter_active", set_active, 1);
    chk("enter_sel", field_sel, 2);
    chk("enter_load", edit_time, {6'd12, 6'd34, 6'd56});
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    chk("hour_up", edit_time[17:12], 13);
    step(0, 0, 0, 0);

    step(1, 0, 0, 0);
    chk("cancel_active", set_active, 0);
    chk("cancel_commit", commit, 0);
    step(0, 0, 0, 0);

    cur_time = {6'd23, 6'd0, 6'd56};
    step(0, 1, 0, 0); step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    chk("hour_wrap", edit_time[17:12], 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0); step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    chk("min_wrap", edit_time[11:6], 59);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0); step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    chk("commit_pulse", commit, 1);
    chk("commit_value", edit_time, {6'd0, 6'd59, 6'd56});
    chk("commit_inactive", set_active, 0);
    step(0, 0, 0, 0);
    chk("commit_one_cycle", commit, 0);

    cur_time = {6'd5, 6'd20, 6'd30};
    step(0, 1, 0, 0); step(0, 0, 0, 0);
    step(0, 0, 1, 1);
    chk("up_down_together", edit_time, {6'd5, 6'd20, 6'd30});
    step(0, 0, 0, 0);
    step(1, 0, 0, 0); step(0, 0, 0, 0);

    cur_time = {6'd12, 6'd58, 6'd0};
    step(0, 1, 0, 0); step(0, 0, 0, 0);
    step(0, 1, 0, 0); step(0, 0, 0, 0);
`ifdef TIME_SET_AUTOREPEAT_EN
    for (int i = 0; i < 30; i++) begin
      step(0, 0, 1, 0);
      k = (i >= RD) ? 2 + (i - RD) / RR : 1;
      chk("repeat_min", edit_time[11:6], (58 + k) % 60);
    end
`else
    for (int i = 0; i < 15; i++) begin
      step(0, 0, 1, 0);
      chk("hold_single_step", edit_time[11:6], 59);
    end
`endif
    step(0, 0, 0, 0);

    n = 0;
    while (n < 40 && set_active) begin step(0, 0, 0, 0); n++; end
    chk("reach_idle", set_active, 0);
    step(0, 1, 0, 0);
    chk("to_enter", set_active, 1);
    n = 0;
    while (n < 40 && !timeout) begin step(0, 0, 0, 0); n++; end
    chk("timeout_cycles", n, TO);
    chk("timeout_inactive", set_active, 0);
    chk("timeout_no_commit", commit, 0);

    step(0, 0, 0, 0);
    cur_time = {6'd1, 6'd40, 6'd2};
    step(0, 1, 0, 0); step(0, 0, 0, 0);
    step(0, 1, 0, 0); step(0, 0, 0, 0);
    chk("pre_rst_min", edit_time[11:6], 40);
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_mid_edit_time", edit_time, 0);
    chk("rst_mid_sel", field_sel, 0);
    chk("rst_mid_active", set_active, 0);
    chk("rst_mid_commit", commit, 0);
    chk("rst_mid_timeout", timeout, 0);
    tick(); tick();
    rst = 1'b0;
    cur_time = {6'd3, 6'd33, 6'd7};
    tick();
    chk("rst_no_commit", commit, 0);
    step(0, 1, 0, 0);
    chk("rst_reload", edit_time, {6'd3, 6'd33, 6'd7});
    chk("rst_reload_sel", field_sel, 2);
    step(0, 0, 0, 0);

    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 11) == 0) bl = ~bl;
      if ($urandom_range(0, 11) == 0) br = ~br;
      if ($urandom_range(0, 19) == 0) bu = ~bu;
      if ($urandom_range(0, 19) == 0) bd = ~bd;
      if ($urandom_range(0, 49) == 0) cur_time = 18'($urandom);
      rst = ($urandom_range(0, 999) == 0);
      tick();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
